req_ack_fifo_server: RTL and testbench

- Buffered responder for the req/ack pull protocol used between producers, async operators and consumers.
- Accepts words on a valid/ready write port and stores them in a FIFO.
- Serves them to one or more pulling requesters, which are async_operator input stages or consumers.
- Acts as a drop-in replacement for the test producer, so arf graphs can be fed from real upstream logic instead of a counter.

---
 rtl/req_ack_fifo_server.sv | 86 ++++++++
 tb/tb_req_ack_fifo_server.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/req_ack_fifo_server.sv
// FIFO-backed responder for the req/ack pull protocol. Words arrive on a
// valid/ready port and are handed out one per ack pulse to all requesters at once.
module req_ack_fifo_server #(
    parameter int data_width  = 32,
    parameter int depth       = 8,
    parameter int output_size = 1,
    parameter int addr_width  = $clog2(depth)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_valid,
    output logic                   wr_ready,
    input  logic [data_width-1:0]  wr_data,
    input  logic [output_size-1:0] req,
    output logic                   ack,
    output logic [data_width-1:0]  dout,
    output logic [31:0]            count,
    output logic [addr_width:0]    level
);

    localparam logic [addr_width:0]   full_level = (addr_width + 1)'(depth);
    localparam logic [addr_width:0]   level_one  = (addr_width + 1)'(1);
    localparam logic [addr_width-1:0] ptr_one    = addr_width'(1);

    logic [data_width-1:0] mem_reg [depth];
    logic [addr_width-1:0] wr_ptr_reg;
    logic [addr_width-1:0] rd_ptr_reg;
    logic [addr_width:0]   level_reg;
    logic [addr_width:0]   level_next;
    logic                  ack_reg;
    logic [data_width-1:0] dout_reg;
    logic [31:0]           count_reg;
    logic                  push;
    logic                  pop;

    // Readiness and pop eligibility look only at registered occupancy, so a
    // slot freed or a word written on this edge becomes visible next cycle.
    assign wr_ready = (level_reg != full_level);
    assign push     = wr_valid & wr_ready;
    assign pop      = (&req) & ~ack_reg & (level_reg != '0);

    always_comb begin
        level_next = level_reg;
        unique case ({push, pop})
            2'b10:   level_next = level_reg + level_one;
            2'b01:   level_next = level_reg - level_one;
            default: level_next = level_reg;
        endcase
    end

    // Storage has no reset so it maps onto block RAM; stale contents are
    // unreachable once the pointers are cleared.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_reg[wr_ptr_reg] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
            ack_reg    <= 1'b0;
            dout_reg   <= '0;
            count_reg  <= '0;
        end else begin
            level_reg <= level_next;
            ack_reg   <= pop;
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + ptr_one;
            end
            if (pop) begin
                dout_reg   <= mem_reg[rd_ptr_reg];
                rd_ptr_reg <= rd_ptr_reg + ptr_one;
                count_reg  <= count_reg + 32'd1;
            end
        end
    end

    assign ack   = ack_reg;
    assign dout  = dout_reg;
    assign count = count_reg;
    assign level = level_reg;

endmodule

// File: tb/tb_req_ack_fifo_server.sv
// Self-checking bench for req_ack_fifo_server: directed scenarios plus a random
// run, all compared against a queue-based model of the served word stream.
module tb_req_ack_fifo_server;

    localparam int DW    = 32;
    localparam int DEPTH = 8;
    localparam int OS    = 2;
    localparam int AW    = $clog2(DEPTH);

    logic          clk = 1'b0;
    logic          rst;
    logic          wr_valid;
    logic          wr_ready;
    logic [DW-1:0] wr_data;
    logic [OS-1:0] req;
    logic          ack;
    logic [DW-1:0] dout;
    logic [31:0]   count;
    logic [AW:0]   level;

    req_ack_fifo_server #(
        .data_width (DW),
        .depth      (DEPTH),
        .output_size(OS)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .wr_valid(wr_valid),
        .wr_ready(wr_ready),
        .wr_data (wr_data),
        .req     (req),
        .ack     (ack),
        .dout    (dout),
        .count   (count),
        .level   (level)
    );

    always #5 clk = ~clk;

    // Reference model: buffered words as a queue, plus the served-word state.
    logic [31:0] mq[$];
    bit          m_ack;
    logic [31:0] m_dout;
    logic [31:0] m_count;
    bit          m_pushed;

    int checks = 0;
    int errors = 0;

    logic [31:0] served[$];
    int          d;
    bit          prev_ack;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock: the model applies the protocol rules to the inputs held
    // across the edge, then outputs are compared on the falling edge.
    task automatic tick();
        bit can_push;
        bit do_pop;
        @(posedge clk);
        m_pushed = 1'b0;
        if (rst) begin
            mq.delete();
            m_ack   = 1'b0;
            m_dout  = '0;
            m_count = '0;
        end else begin
            can_push = wr_valid && (mq.size() < DEPTH);
            do_pop   = (&req) && !m_ack && (mq.size() != 0);
            if (do_pop) begin
                m_dout  = mq.pop_front();
                m_count = m_count + 1;
            end
            m_ack = do_pop;
            if (can_push) begin
                mq.push_back(wr_data);
                m_pushed = 1'b1;
            end
        end
        @(negedge clk);
        check("ack", ack, m_ack);
        check("dout", dout, m_dout);
        check("count", count, m_count);
        check("level", level, mq.size());
        check("wr_ready", wr_ready, mq.size() < DEPTH);
    endtask

    task automatic do_reset();
        rst = 1'b1; wr_valid = 1'b0; req = '0; wr_data = '0;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        m_ack = 1'b0; m_dout = '0; m_count = '0; m_pushed = 1'b0;
        rst = 1'b1; wr_valid = 1'b1; req = '1; wr_data = 32'hDEAD_BEEF;
        @(negedge clk);

        // Reset held two cycles with writes and requests active
        for (int i = 0; i < 2; i++) begin
            tick();
            check("rst_ack", ack, 0);
            check("rst_level", level, 0);
            check("rst_wr_ready", wr_ready, 1);
        end
        rst = 1'b0; wr_valid = 1'b0; req = '0;
        tick();
        check("post_rst_ack", ack, 0);
        check("post_rst_count", count, 0);

        // Single word with requests held
        do_reset();
        req = '1; wr_valid = 1'b1; wr_data = 32'h0000_00A5;
        tick();
        wr_valid = 1'b0;
        tick();
        check("single_ack", ack, 1);
        check("single_dout", dout, 32'hA5);
        tick();
        check("single_ack_low", ack, 0);
        check("single_count", count, 1);
        check("single_level", level, 0);

        // Fill to full with no requests, then drain in order
        do_reset();
        d = 0;
        for (int i = 0; i < 12; i++) begin
            wr_valid = 1'b1; wr_data = d;
            tick();
            if (m_pushed) d++;
        end
        check("full_level", level, DEPTH);
        check("full_wr_ready", wr_ready, 0);
        check("full_accepted", d, 8);
        req = '1; served.delete(); prev_ack = 1'b0;
        for (int i = 0; i < 80 && served.size() < 10; i++) begin
            wr_valid = (d < 10); wr_data = d;
            tick();
            if (m_pushed) d++;
            if (ack) begin
                served.push_back(dout);
                check("full_no_b2b_ack", prev_ack, 0);
            end
            prev_ack = ack;
        end
        check("full_served_n", served.size(), 10);
        for (int k = 0; k < served.size(); k++) check("full_order", served[k], k);

        // Long stream through many pointer wraps
        begin
            int first_ack = -1;
            int last_ack  = -1;
            int bad       = -1;
            do_reset();
            req = '1; d = 0; served.delete();
            for (int cyc = 0; cyc < 12000 && served.size() < 5000; cyc++) begin
                wr_valid = (d < 5000); wr_data = d;
                tick();
                if (m_pushed) d++;
                check("wrap_level_max", level <= DEPTH, 1);
                if (ack) begin
                    if (first_ack < 0) first_ack = cyc;
                    last_ack = cyc;
                    served.push_back(dout);
                end
            end
            for (int k = 0; k < served.size(); k++)
                if (bad < 0 && served[k] != k) bad = k;
            check("wrap_served_n", served.size(), 5000);
            check("wrap_first_bad_index", bad, -1);
            check("wrap_count", count, 5000);
            check("wrap_ack_span", last_ack - first_ack, 2 * 4999);
        end

        // Fan-out: partial request never pops
        do_reset();
        wr_valid = 1'b1; wr_data = 32'h11;
        tick();
        wr_data = 32'h22;
        tick();
        wr_valid = 1'b0; req = 2'b01;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("fanout_partial_ack", ack, 0);
        end
        req = 2'b11; served.delete();
        for (int i = 0; i < 10 && served.size() < 2; i++) begin
            tick();
            if (ack) served.push_back(dout);
        end
        check("fanout_served_n", served.size(), 2);
        if (served.size() == 2) begin
            check("fanout_first", served[0], 32'h11);
            check("fanout_second", served[1], 32'h22);
        end

        // Reset mid-stream discards buffered words
        do_reset();
        for (int i = 0; i < 5; i++) begin
            wr_valid = 1'b1; wr_data = 32'h100 + i;
            tick();
        end
        check("mid_level_before", level, 5);
        rst = 1'b1; wr_valid = 1'b0;
        tick();
        rst = 1'b0;
        check("mid_level_after", level, 0);
        check("mid_count_after", count, 0);
        wr_valid = 1'b1; wr_data = 32'h77; req = '1;
        tick();
        wr_valid = 1'b0;
        served.delete();
        for (int i = 0; i < 8; i++) begin
            tick();
            if (ack) served.push_back(dout);
        end
        check("mid_served_n", served.size(), 1);
        if (served.size() == 1) check("mid_first_word", served[0], 32'h77);

        // Random traffic, occasional reset
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            rst      = ($urandom_range(0, 199) == 0);
            wr_valid = $urandom_range(0, 1);
            req      = OS'($urandom_range(0, 3));
            wr_data  = $urandom;
            tick();
        end
        rst = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
